// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus port between the I-cache (r0)
// and the D-cache (r1). One transaction at a time, with a response watchdog.
//
// Ports: clock / reset (async, active-high)
//   rN_req_*  : requester N request in, rN_req_ready out (IDLE only)
//   rN_resp_* : registered one-cycle response pulse to the owning requester
//   m_req_*   : registered downstream request, m_resp_* downstream response
//   owner     : current/last grant owner, busy : FSM not in IDLE
module mem_bus_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                r0_req_valid,
  input  logic [ADDR_W-1:0]   r0_req_addr,
  input  logic                r0_req_write,
  input  logic [DATA_W-1:0]   r0_req_wdata,
  input  logic [DATA_W/8-1:0] r0_req_wstrb,
  output logic                r0_req_ready,
  output logic                r0_resp_valid,
  output logic [DATA_W-1:0]   r0_resp_rdata,
  output logic                r0_resp_err,
  input  logic                r1_req_valid,
  input  logic [ADDR_W-1:0]   r1_req_addr,
  input  logic                r1_req_write,
  input  logic [DATA_W-1:0]   r1_req_wdata,
  input  logic [DATA_W/8-1:0] r1_req_wstrb,
  output logic                r1_req_ready,
  output logic                r1_resp_valid,
  output logic [DATA_W-1:0]   r1_resp_rdata,
  output logic                r1_resp_err,
  output logic                m_req_valid,
  input  logic                m_req_ready,
  output logic [ADDR_W-1:0]   m_req_addr,
  output logic                m_req_write,
  output logic [DATA_W-1:0]   m_req_wdata,
  output logic [DATA_W/8-1:0] m_req_wstrb,
  input  logic                m_resp_valid,
  input  logic [DATA_W-1:0]   m_resp_rdata,
  input  logic                m_resp_err,
  output logic                owner,
  output logic                busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit WD_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_RESP, S_DRAIN
  } state_e;

  state_e state_q, state_d;

  logic              last_q, last_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [1:0]             rvalid_q, rvalid_d;
  logic [1:0]             rerr_q, rerr_d;
  logic [1:0][DATA_W-1:0] rdata_q, rdata_d;

  logic       any_req;
  logic       win;
  logic       accept;
  logic       to_hit;
  logic [1:0] grant;

  // Tie goes to whoever did not win last; a lone requester always wins.
  assign any_req = r0_req_valid | r1_req_valid;
  assign win     = (r0_req_valid & r1_req_valid) ? ~last_q : r1_req_valid;
  assign accept  = (state_q == S_IDLE) & any_req;
  assign to_hit  = WD_EN & (cnt_q == CNT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (any_req)      state_d = S_REQ;
      S_REQ:   if (m_req_ready)  state_d = S_RESP;
      S_RESP: begin
        if (m_resp_valid)        state_d = S_IDLE;
        else if (to_hit)         state_d = S_DRAIN;
      end
      S_DRAIN: if (m_resp_valid) state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant        = 2'b00;
    grant[win]   = accept;
    r0_req_ready = grant[0];
    r1_req_ready = grant[1];
    m_req_valid  = (state_q == S_REQ);
    busy         = (state_q != S_IDLE);
  end

  // Datapath: holding registers, watchdog counter, response registers.
  always_comb begin
    last_d   = last_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    cnt_d    = cnt_q;
    rvalid_d = '0;
    rerr_d   = '0;
    rdata_d  = '0;
    if (accept) begin
      last_d  = win;
      owner_d = win;
      addr_d  = win ? r1_req_addr  : r0_req_addr;
      write_d = win ? r1_req_write : r0_req_write;
      wdata_d = win ? r1_req_wdata : r0_req_wdata;
      wstrb_d = win ? r1_req_wstrb : r0_req_wstrb;
    end
    if (state_q == S_REQ && m_req_ready) begin
      cnt_d = '0;
    end else if (state_q == S_RESP && !m_resp_valid && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (state_q == S_RESP) begin
      if (m_resp_valid) begin
        rvalid_d[owner_q] = 1'b1;
        rerr_d[owner_q]   = m_resp_err;
        rdata_d[owner_q]  = m_resp_rdata;
      end else if (to_hit) begin
        rvalid_d[owner_q] = 1'b1;
        rerr_d[owner_q]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      cnt_q    <= '0;
      rvalid_q <= '0;
      rerr_q   <= '0;
      rdata_q  <= '0;
    end else begin
      last_q   <= last_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
      rdata_q  <= rdata_d;
    end
  end

  assign m_req_addr    = addr_q;
  assign m_req_write   = write_q;
  assign m_req_wdata   = wdata_q;
  assign m_req_wstrb   = wstrb_q;
  assign owner         = owner_q;
  assign r0_resp_valid = rvalid_q[0];
  assign r0_resp_err   = rerr_q[0];
  assign r0_resp_rdata = rdata_q[0];
  assign r1_resp_valid = rvalid_q[1];
  assign r1_resp_err   = rerr_q[1];
  assign r1_resp_rdata = rdata_q[1];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (TIMEOUT=8).
// Linear stimulus with immediate assertions at each check point.
module tb_mem_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        r0_req_valid, r0_req_write, r0_req_ready;
  logic [63:0] r0_req_addr, r0_req_wdata, r0_resp_rdata;
  logic [7:0]  r0_req_wstrb;
  logic        r0_resp_valid, r0_resp_err;
  logic        r1_req_valid, r1_req_write, r1_req_ready;
  logic [63:0] r1_req_addr, r1_req_wdata, r1_resp_rdata;
  logic [7:0]  r1_req_wstrb;
  logic        r1_resp_valid, r1_resp_err;
  logic        m_req_valid, m_req_ready, m_req_write;
  logic [63:0] m_req_addr, m_req_wdata, m_resp_rdata;
  logic [7:0]  m_req_wstrb;
  logic        m_resp_valid, m_resp_err;
  logic        owner, busy;

  int passed = 0;
  int total  = 0;
  int hs     = 0;
  logic e;

  mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .r0_req_valid(r0_req_valid), .r0_req_addr(r0_req_addr),
    .r0_req_write(r0_req_write), .r0_req_wdata(r0_req_wdata),
    .r0_req_wstrb(r0_req_wstrb), .r0_req_ready(r0_req_ready),
    .r0_resp_valid(r0_resp_valid), .r0_resp_rdata(r0_resp_rdata),
    .r0_resp_err(r0_resp_err),
    .r1_req_valid(r1_req_valid), .r1_req_addr(r1_req_addr),
    .r1_req_write(r1_req_write), .r1_req_wdata(r1_req_wdata),
    .r1_req_wstrb(r1_req_wstrb), .r1_req_ready(r1_req_ready),
    .r1_resp_valid(r1_resp_valid), .r1_resp_rdata(r1_resp_rdata),
    .r1_resp_err(r1_resp_err),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_req_addr(m_req_addr), .m_req_write(m_req_write),
    .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
    .m_resp_valid(m_resp_valid), .m_resp_rdata(m_resp_rdata),
    .m_resp_err(m_resp_err),
    .owner(owner), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    r0_req_valid = 0; r0_req_addr = 0; r0_req_write = 0;
    r0_req_wdata = 0; r0_req_wstrb = 0;
    r1_req_valid = 0; r1_req_addr = 0; r1_req_write = 0;
    r1_req_wdata = 0; r1_req_wstrb = 0;
    m_req_ready = 0; m_resp_valid = 0; m_resp_rdata = 0; m_resp_err = 0;
    repeat (2) cyc();
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_mvalid", m_req_valid, 0);
    check("rst_maddr", m_req_addr, 0);
    check("rst_r0_resp", r0_resp_valid, 0);
    check("rst_r1_resp", r1_resp_valid, 0);
    reset = 1'b0;
    cyc();

    // Both requesters held valid: r0, r1, r0, r1.
    r0_req_valid = 1; r0_req_addr = 64'h10;
    r1_req_valid = 1; r1_req_addr = 64'h20;
    m_req_ready = 1;
    for (int i = 0; i < 4; i++) begin
      e = (i % 2) == 1;
      #1;
      check("tie_r0_rdy", r0_req_ready, !e);
      check("tie_r1_rdy", r1_req_ready, e);
      cyc();
      check("tie_owner", owner, e);
      check("tie_mvalid", m_req_valid, 1);
      check("tie_maddr", m_req_addr, e ? 64'h20 : 64'h10);
      check("tie_no_rdy", {r0_req_ready, r1_req_ready}, 0);
      cyc();
      m_resp_valid = 1; m_resp_rdata = 64'hA0 + 64'(i);
      cyc();
      m_resp_valid = 0;
      if (i == 3) begin
        r0_req_valid = 0; r1_req_valid = 0;
      end
      #1;
      check("tie_r0_resp", r0_resp_valid, !e);
      check("tie_r1_resp", r1_resp_valid, e);
      check("tie_rdata", e ? r1_resp_rdata : r0_resp_rdata,
            64'hA0 + 64'(i));
    end

    // Single load from r0.
    cyc();
    r0_req_valid = 1; r0_req_addr = 64'h100; r0_req_write = 0;
    #1;
    check("ld_r0_rdy", r0_req_ready, 1);
    check("ld_r1_rdy", r1_req_ready, 0);
    cyc();
    r0_req_valid = 0;
    #1;
    check("ld_mvalid", m_req_valid, 1);
    check("ld_maddr", m_req_addr, 64'h100);
    check("ld_mwrite", m_req_write, 0);
    check("ld_r0_rdy_off", r0_req_ready, 0);
    cyc();
    check("ld_mvalid_off", m_req_valid, 0);
    check("ld_busy", busy, 1);
    cyc();
    m_resp_valid = 1; m_resp_rdata = 64'hDEADBEEF;
    cyc();
    m_resp_valid = 0;
    #1;
    check("ld_r0_resp", r0_resp_valid, 1);
    check("ld_rdata", r0_resp_rdata, 64'hDEADBEEF);
    check("ld_err", r0_resp_err, 0);
    check("ld_r1_resp", r1_resp_valid, 0);
    check("ld_idle", busy, 0);
    cyc();
    check("ld_pulse_end", r0_resp_valid, 0);

    // r1 store with a stalled downstream.
    r1_req_valid = 1; r1_req_addr = 64'h2000; r1_req_write = 1;
    r1_req_wdata = 64'h1122334455667788; r1_req_wstrb = 8'h0F;
    m_req_ready = 0;
    #1;
    check("st_r1_rdy", r1_req_ready, 1);
    cyc();
    r1_req_valid = 0; r1_req_addr = 64'hFFFF; r1_req_write = 0;
    r1_req_wdata = 0; r1_req_wstrb = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (m_req_valid && m_req_ready) hs++;
      check("st_mvalid", m_req_valid, 1);
      check("st_maddr", m_req_addr, 64'h2000);
      check("st_mwrite", m_req_write, 1);
      check("st_mwdata", m_req_wdata, 64'h1122334455667788);
      check("st_mwstrb", m_req_wstrb, 8'h0F);
      cyc();
    end
    m_req_ready = 1;
    #1;
    if (m_req_valid && m_req_ready) hs++;
    cyc();
    check("st_mvalid_off", m_req_valid, 0);
    check("st_handshakes", hs, 1);
    m_resp_valid = 1; m_resp_rdata = 0;
    cyc();
    m_resp_valid = 0;
    #1;
    check("st_r1_resp", r1_resp_valid, 1);
    check("st_r0_resp", r0_resp_valid, 0);

    // Watchdog timeout on r0, then drain a late response.
    cyc();
    r0_req_valid = 1; r0_req_addr = 64'h300;
    #1;
    check("to_r0_rdy", r0_req_ready, 1);
    cyc();
    r0_req_valid = 0;
    cyc();
    for (int k = 0; k < 8; k++) begin
      check("to_wait", r0_resp_valid, 0);
      cyc();
    end
    check("to_r0_resp", r0_resp_valid, 1);
    check("to_err", r0_resp_err, 1);
    check("to_rdata", r0_resp_rdata, 0);
    check("to_drain_busy", busy, 1);
    r1_req_valid = 1; r1_req_addr = 64'h400; r1_req_write = 0;
    #1;
    check("dr_r1_rdy0", r1_req_ready, 0);
    cyc();
    check("dr_r1_rdy1", r1_req_ready, 0);
    check("dr_pulse_end", r0_resp_valid, 0);
    cyc();
    check("dr_r1_rdy2", r1_req_ready, 0);
    cyc();
    m_resp_valid = 1; m_resp_rdata = 64'h55;
    #1;
    check("dr_r1_rdy3", r1_req_ready, 0);
    check("dr_busy", busy, 1);
    cyc();
    m_resp_valid = 0;
    #1;
    check("dr_no_r0", r0_resp_valid, 0);
    check("dr_no_r1", r1_resp_valid, 0);
    check("dr_idle", busy, 0);
    check("dr_r1_grant", r1_req_ready, 1);
    cyc();
    r1_req_valid = 0;
    #1;
    check("dr_owner", owner, 1);
    check("dr_maddr", m_req_addr, 64'h400);

    // Downstream error forwarded to owner only.
    cyc();
    m_resp_valid = 1; m_resp_err = 1; m_resp_rdata = 64'h77;
    cyc();
    m_resp_valid = 0; m_resp_err = 0;
    #1;
    check("er_r1_resp", r1_resp_valid, 1);
    check("er_r1_err", r1_resp_err, 1);
    check("er_r1_rdata", r1_resp_rdata, 64'h77);
    check("er_r0_resp", r0_resp_valid, 0);
    check("er_r0_err", r0_resp_err, 0);

    // Reset in RESP after an r0 grant (last owner = r0).
    cyc();
    r0_req_valid = 1; r0_req_addr = 64'h500;
    cyc();
    r0_req_valid = 0;
    cyc();
    check("mr_busy_pre", busy, 1);
    reset = 1;
    #1;
    check("mr_busy", busy, 0);
    check("mr_owner", owner, 0);
    check("mr_mvalid", m_req_valid, 0);
    check("mr_maddr", m_req_addr, 0);
    check("mr_r0_resp", r0_resp_valid, 0);
    cyc();
    reset = 0;
    r0_req_valid = 1; r1_req_valid = 1;
    #1;
    check("mr_r0_rdy", r0_req_ready, 1);
    check("mr_r1_rdy", r1_req_ready, 0);
    cyc();
    r0_req_valid = 0; r1_req_valid = 0;
    #1;
    check("mr_owner_r0", owner, 0);
    check("mr_maddr_r0", m_req_addr, 64'h500);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
